fir_coef_ctrl: RTL and testbench

- Run-time coefficient controller for the 21-tap symmetric (11 unique coefficient) sine/pulse-shaping FIR.
- Accepts a coefficient set over a valid/ready stream into a shadow bank.
- Commits the shadow bank to the active bank only on a filter sample-strobe boundary, so the datapath never computes with a mixed set.
- Drives the FIR's coefficient inputs; replaces the hard-coded initial coefficient block.

---
 rtl/fir_coef_pkg.sv | 27 ++
 rtl/fir_coef_bank.sv | 47 ++++
 rtl/fir_coef_ctrl.sv | 124 ++++++++++++
 tb/tb_fir_coef_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_pkg.sv
// Shared constants, types and reset coefficients for the run-time FIR coefficient controller.
package fir_coef_pkg;

    localparam int unsigned NUM_TAPS = 11;
    localparam int unsigned COEF_W   = 18;
    localparam int unsigned IDX_W    = 4;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t coef_arr_t [NUM_TAPS];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2
    } state_e;

    // Most negative code has no positive counterpart; it is stored as COEF_MIN_SAFE.
    localparam coef_t COEF_MOST_NEG = {1'b1, {(COEF_W-1){1'b0}}};
    localparam coef_t COEF_MIN_SAFE = -18'sd131071;

    localparam coef_arr_t COEF_DEFAULT = '{
        18'sd4094,   18'sd5900,   18'sd3326,  -18'sd3449,
        -18'sd10679, -18'sd12462, -18'sd4029,  18'sd14915,
        18'sd38991,  18'sd59143,  18'sd66990
    };

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair: indexed shadow write, all-taps commit to active.
module fir_coef_bank
    import fir_coef_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  coef_t                        wr_data,
    input  logic                         commit,
    output logic [NUM_TAPS*COEF_W-1:0]   coef_flat
);

    coef_arr_t shadow_q, shadow_d;
    coef_arr_t active_q, active_d;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
        if (commit) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '{default: '0};
            active_q <= COEF_DEFAULT;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        coef_flat = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            coef_flat[i*COEF_W +: COEF_W] = active_q[i];
        end
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient load controller: streams a set into the shadow bank and swaps it
// into the active bank only on a sample strobe, so the FIR never sees a mixed set.
module fir_coef_ctrl
    import fir_coef_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         samp_en,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic [COEF_W-1:0]            cfg_data,
    output logic                         cfg_ready,
    output logic [NUM_TAPS*COEF_W-1:0]   coef_flat,
    output logic                         busy,
    output logic                         swap_pulse,
    output logic                         err
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               busy_q, busy_d;
    logic               swap_pulse_q, swap_pulse_d;
    logic               err_q, err_d;

    logic               wr_en_c;
    coef_t              wr_data_c;
    logic               commit_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            swap_pulse_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            swap_pulse_q <= swap_pulse_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_d        = err_q;
        swap_pulse_d = 1'b0;
        wr_en_c      = 1'b0;
        wr_data_c    = coef_t'(cfg_data);
        commit_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end

            ST_LOAD: begin
                // A restart beats a coincident transfer; that word is dropped.
                if (cfg_start) begin
                    idx_d = '0;
                    err_d = 1'b1;
                end else if (cfg_valid && cfg_ready_q) begin
                    wr_en_c = 1'b1;
                    if (cfg_data == COEF_MOST_NEG) begin
                        wr_data_c = COEF_MIN_SAFE;
                        err_d     = 1'b1;
                    end
                    if (idx_q == IDX_W'(NUM_TAPS - 1)) begin
                        state_d = ST_ARM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_ARM: begin
                // The sample strobe wins over a simultaneous restart.
                if (samp_en) begin
                    commit_c     = 1'b1;
                    swap_pulse_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (cfg_start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        cfg_ready_d = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
    end

    fir_coef_bank u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en_c),
        .wr_idx    (idx_q),
        .wr_data   (wr_data_c),
        .commit    (commit_c),
        .coef_flat (coef_flat)
    );

    assign cfg_ready  = cfg_ready_q;
    assign busy       = busy_q;
    assign swap_pulse = swap_pulse_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: load, backpressure, restart/abort, clamp and async reset.
module tb_fir_coef_ctrl;

    typedef logic signed [17:0] c_t;
    typedef c_t set_t [11];

    logic          clk = 1'b0;
    logic          reset;
    logic          samp_en;
    logic          cfg_start;
    logic          cfg_valid;
    logic [17:0]   cfg_data;
    logic          cfg_ready;
    logic [197:0]  coef_flat;
    logic          busy;
    logic          swap_pulse;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    set_t DEF  = '{18'sd4094, 18'sd5900, 18'sd3326, -18'sd3449, -18'sd10679, -18'sd12462,
                   -18'sd4029, 18'sd14915, 18'sd38991, 18'sd59143, 18'sd66990};
    set_t PB   = '{18'sd2817, 18'sd4060, 18'sd2289, -18'sd2373, -18'sd7348, -18'sd8574,
                   -18'sd2772, 18'sd10263, 18'sd26830, 18'sd40696, 18'sd46096};
    set_t SC   = '{18'sd100, -18'sd200, 18'sd300, -18'sd400, 18'sd500, -18'sd600,
                   18'sd700, -18'sd800, 18'sd900, -18'sd1000, 18'sd1100};
    set_t SX   = '{18'sd7777, 18'sd7777, 18'sd7777, 18'sd7777, 18'sd7777, 18'sd7777,
                   18'sd7777, 18'sd7777, 18'sd7777, 18'sd7777, 18'sd7777};
    set_t SD   = '{18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd5, 18'sd6,
                   18'sd7, 18'sd8, 18'sd9, 18'sd10, 18'sd11};
    set_t SE   = '{-18'sd1, -18'sd2, -18'sd3, -18'sd4, -18'sd5, -18'sd6,
                   -18'sd7, -18'sd8, -18'sd9, -18'sd10, -18'sd11};
    set_t SF   = '{18'sd131071, -18'sd131071, 18'sd0, 18'sd1, -18'sd1, 18'sd2,
                   -18'sd2, 18'sd3, -18'sd3, 18'sd4, -18'sd4};
    set_t SG   = '{18'sd10, 18'sd20, 18'sd30, 18'sd40, 18'sd50, 18'sd60,
                   18'sd70, 18'sd80, 18'sd90, 18'sd100, 18'sd110};
    set_t SH   = '{18'sd11, 18'sd22, 18'sd33, 18'sd44, 18'sh20000, 18'sd66,
                   18'sd77, 18'sd88, 18'sd99, 18'sd110, 18'sd121};
    set_t SH_X = '{18'sd11, 18'sd22, 18'sd33, 18'sd44, -18'sd131071, 18'sd66,
                   18'sd77, 18'sd88, 18'sd99, 18'sd110, 18'sd121};

    fir_coef_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .samp_en    (samp_en),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .coef_flat  (coef_flat),
        .busy       (busy),
        .swap_pulse (swap_pulse),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [197:0] pack(input set_t s);
        logic [197:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) v[i*18 +: 18] = s[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [197:0] obs, input logic [197:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples both live 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic strobe();
        samp_en = 1'b1;
        tick();
        samp_en = 1'b0;
    endtask

    task automatic send_words(input string tag, input set_t s, input int n, input bit gaps);
        int  sent = 0;
        int  budget = 0;
        logic rdy;
        while (sent < n && budget < 300) begin
            cfg_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            cfg_data  = s[sent];
            rdy       = cfg_ready;
            tick();
            if (cfg_valid && rdy) sent++;
            budget++;
        end
        cfg_valid = 1'b0;
        chk(tag, 198'(sent), 198'(n));
    endtask

    initial begin
        reset     = 1'b0;
        samp_en   = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;

        // Reset
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_coef", coef_flat, pack(DEF));
        chk("rst_b10", 198'($signed(coef_flat[10*18 +: 18])), 198'(DEF[10]));
        chk("rst_b3", 198'($signed(coef_flat[3*18 +: 18])), 198'(DEF[3]));
        chk("rst_ready", 198'(cfg_ready), 198'(0));
        chk("rst_busy", 198'(busy), 198'(0));
        chk("rst_err", 198'(err), 198'(0));
        chk("rst_swap", 198'(swap_pulse), 198'(0));

        // Normal load with valid held high
        start_pulse();
        chk("load_busy", 198'(busy), 198'(1));
        for (int k = 0; k < 11; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = PB[k];
            chk($sformatf("load_ready_%0d", k), 198'(cfg_ready), 198'(1));
            tick();
        end
        chk("arm_ready_low", 198'(cfg_ready), 198'(0));
        cfg_data = 18'd999;
        tick();
        cfg_valid = 1'b0;
        chk("arm_busy", 198'(busy), 198'(1));
        chk("arm_no_swap_yet", coef_flat, pack(DEF));
        tick();
        chk("arm_hold", coef_flat, pack(DEF));
        chk("arm_swap_low", 198'(swap_pulse), 198'(0));
        strobe();
        chk("swap_coef", coef_flat, pack(PB));
        chk("swap_pulse_hi", 198'(swap_pulse), 198'(1));
        chk("swap_idle", 198'(busy), 198'(0));
        tick();
        chk("swap_pulse_lo", 198'(swap_pulse), 198'(0));
        chk("swap_err", 198'(err), 198'(0));

        // Backpressure with random valid gaps
        start_pulse();
        send_words("bp_count", SC, 11, 1'b1);
        chk("bp_ready_low", 198'(cfg_ready), 198'(0));
        repeat (3) tick();
        chk("bp_no_early_swap", coef_flat, pack(PB));
        chk("bp_swap_low", 198'(swap_pulse), 198'(0));
        strobe();
        chk("bp_coef", coef_flat, pack(SC));
        chk("bp_swap", 198'(swap_pulse), 198'(1));

        // Restart after 5 words, with a coincident dropped transfer
        start_pulse();
        send_words("rs_part", SX, 5, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 18'd4321;
        start_pulse();
        cfg_valid = 1'b0;
        chk("rs_err", 198'(err), 198'(1));
        chk("rs_ready", 198'(cfg_ready), 198'(1));
        send_words("rs_full", SD, 11, 1'b0);
        strobe();
        chk("rs_coef", coef_flat, pack(SD));
        chk("rs_err_sticky", 198'(err), 198'(1));

        // Start from IDLE clears err; abort from ARM
        start_pulse();
        chk("idle_start_clr", 198'(err), 198'(0));
        send_words("ab_full", SE, 11, 1'b0);
        start_pulse();
        chk("ab_busy", 198'(busy), 198'(1));
        chk("ab_ready", 198'(cfg_ready), 198'(1));
        chk("ab_err", 198'(err), 198'(1));
        strobe();
        chk("ab_no_swap", 198'(swap_pulse), 198'(0));
        chk("ab_coef_kept", coef_flat, pack(SD));
        send_words("ab_reload", SF, 11, 1'b0);
        strobe();
        chk("ab_coef_new", coef_flat, pack(SF));

        // Start and strobe together in ARM: swap wins, no error
        start_pulse();
        send_words("ss_full", SG, 11, 1'b0);
        cfg_start = 1'b1;
        samp_en   = 1'b1;
        tick();
        cfg_start = 1'b0;
        samp_en   = 1'b0;
        chk("ss_coef", coef_flat, pack(SG));
        chk("ss_swap", 198'(swap_pulse), 198'(1));
        chk("ss_err", 198'(err), 198'(0));
        chk("ss_idle", 198'(busy), 198'(0));

        // Most-negative code is clamped and flags err
        start_pulse();
        send_words("cl_full", SH, 11, 1'b0);
        strobe();
        chk("cl_coef", coef_flat, pack(SH_X));
        chk("cl_b4", 198'($signed(coef_flat[4*18 +: 18])), 198'(-18'sd131071));
        chk("cl_err", 198'(err), 198'(1));
        start_pulse();
        chk("cl_err_clr", 198'(err), 198'(0));

        // Async reset while armed
        send_words("ar_full", PB, 11, 1'b0);
        chk("ar_armed", 198'(busy), 198'(1));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_coef", coef_flat, pack(DEF));
        chk("ar_busy", 198'(busy), 198'(0));
        chk("ar_ready", 198'(cfg_ready), 198'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        strobe();
        chk("ar_no_swap", 198'(swap_pulse), 198'(0));
        chk("ar_coef_kept", coef_flat, pack(DEF));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
